// File: rtl/brg_hb_csr_pkg.sv
// brg_hb_csr_pkg: CSR response types, freeze CSR address and entry macros
`ifndef BRG_HB_CSR_PKG_SV
`define BRG_HB_CSR_PKG_SV

`define BRG_HB_CSR_RESP_ENTRY_WIDTH(x_mp, y_mp, d_mp, id_mp) (2 + (d_mp) + (id_mp) + (x_mp) + (y_mp))

`define DECLARE_BRG_HB_CSR_RESP_ENTRY_S(x_mp, y_mp, d_mp, id_mp) \
  typedef struct packed { \
    csr_ret_type_e ret_type; \
    logic [(d_mp)-1:0] data; \
    logic [(id_mp)-1:0] load_id; \
    logic [(x_mp)-1:0] x; \
    logic [(y_mp)-1:0] y; \
  } csr_resp_entry_s

package brg_hb_csr_pkg;
  localparam int csr_freeze_addr_gp = 'h8000;
  typedef enum logic [1:0] {
    e_ret_store_ack = 2'd0,
    e_ret_load = 2'd1,
    e_ret_error = 2'd2
  } csr_ret_type_e;
endpackage

`endif

// File: rtl/brg_hb_csr_resp_fifo.sv
// brg_hb_csr_resp_fifo: in-order response FIFO with async reset, v/ready both sides and occupancy count
module brg_hb_csr_resp_fifo #(
  parameter int width_p = 8,
  parameter int els_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);
  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic enq, deq;
  // next-state for pointers and count; full blocks enqueue even when dequeuing
  always_comb begin
    ready_o = count_q != cnt_w'(els_p);
    v_o = count_q != '0;
    enq = v_i & ready_o;
    deq = v_o & yumi_i;
    wptr_d = enq ? wptr_q + ptr_w'(1) : wptr_q;
    rptr_d = deq ? rptr_q + ptr_w'(1) : rptr_q;
    count_d = count_q + cnt_w'(enq) - cnt_w'(deq);
  end
  // pointer and count state, cleared asynchronously
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset; validity is tracked by count
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end
  assign data_o = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/brg_hb_csr_response_unit.sv
// brg_hb_csr_response_unit: buffers CSR responses and emits return packets; BRG_HB_CSR_RESP_STATS_EN adds per-type dequeue counters
module brg_hb_csr_response_unit
  import brg_hb_csr_pkg::*;
#(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int load_id_width_p = 5,
  parameter int fifo_els_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [x_cord_width_p-1:0]        my_x_i,
  input  logic [y_cord_width_p-1:0]        my_y_i,
  input  logic                             req_v_i,
  input  logic                             req_we_i,
  input  logic [addr_width_p-1:0]          req_addr_i,
  input  logic [load_id_width_p-1:0]       req_load_id_i,
  input  logic [x_cord_width_p-1:0]        req_src_x_i,
  input  logic [y_cord_width_p-1:0]        req_src_y_i,
  output logic                             req_ready_o,
  input  logic                             freeze_i,
  output logic                             ret_v_o,
  input  logic                             ret_ready_i,
  output logic [1:0]                       ret_type_o,
  output logic [data_width_p-1:0]          ret_data_o,
  output logic [load_id_width_p-1:0]       ret_load_id_o,
  output logic [x_cord_width_p-1:0]        ret_x_o,
  output logic [y_cord_width_p-1:0]        ret_y_o,
`ifdef BRG_HB_CSR_RESP_STATS_EN
  output logic [15:0]                      ack_count_o,
  output logic [15:0]                      load_count_o,
  output logic [15:0]                      err_count_o,
`endif
  output logic [$clog2(fifo_els_p+1)-1:0]  pending_o
);
  `DECLARE_BRG_HB_CSR_RESP_ENTRY_S(x_cord_width_p, y_cord_width_p, data_width_p, load_id_width_p);
  localparam int entry_w = `BRG_HB_CSR_RESP_ENTRY_WIDTH(x_cord_width_p, y_cord_width_p, data_width_p, load_id_width_p);
  csr_resp_entry_s enq_entry, head;
  logic [entry_w-1:0] head_raw;
  logic hit, fifo_ready, deq;
  // build the response entry in the request cycle, sampling freeze before any write lands
  always_comb begin
    hit = req_addr_i == addr_width_p'(csr_freeze_addr_gp);
    enq_entry.ret_type = !hit ? e_ret_error : req_we_i ? e_ret_store_ack : e_ret_load;
    enq_entry.data = (hit && !req_we_i) ? data_width_p'(freeze_i) : '0;
    enq_entry.load_id = req_load_id_i;
    enq_entry.x = req_src_x_i;
    enq_entry.y = req_src_y_i;
  end
  brg_hb_csr_resp_fifo #(.width_p(entry_w), .els_p(fifo_els_p)) fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(req_v_i),
    .data_i(enq_entry),
    .ready_o(fifo_ready),
    .v_o(ret_v_o),
    .data_o(head_raw),
    .yumi_i(ret_ready_i),
    .count_o(pending_o)
  );
  assign head = head_raw;
  assign req_ready_o = fifo_ready & ~reset_i;
  assign deq = ret_v_o & ret_ready_i;
  assign ret_type_o = head.ret_type;
  assign ret_data_o = head.data;
  assign ret_load_id_o = head.load_id;
  assign ret_x_o = head.x;
  assign ret_y_o = head.y;
  wire unused_ok = &{1'b0, my_x_i, my_y_i};
  assert property (@(posedge clk_i) disable iff (reset_i) !(req_v_i && !req_ready_o))
    else $error("req_v_i while full: response dropped");
`ifdef BRG_HB_CSR_RESP_STATS_EN
  logic [15:0] ack_q, ack_d, load_q, load_d, err_q, err_d;
  // saturating per-type counts of dequeued packets
  always_comb begin
    ack_d = (deq && head.ret_type == e_ret_store_ack && ack_q != 16'hFFFF) ? ack_q + 16'd1 : ack_q;
    load_d = (deq && head.ret_type == e_ret_load && load_q != 16'hFFFF) ? load_q + 16'd1 : load_q;
    err_d = (deq && head.ret_type == e_ret_error && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end
  // counter state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ack_q <= '0;
      load_q <= '0;
      err_q <= '0;
    end else begin
      ack_q <= ack_d;
      load_q <= load_d;
      err_q <= err_d;
    end
  end
  assign ack_count_o = ack_q;
  assign load_count_o = load_q;
  assign err_count_o = err_q;
`endif
endmodule
